// File: rtl/instr_field_merge_pkg.sv
// Instruction-format package for the field merger.
// Holds the field_sel encodings, the MIPS field bit positions and a helper
// that turns a field_sel code into a bit mask (1 = bit comes from the donor word).
package instr_fmt_pkg;

    // Widest instruction word the mask helper can describe.
    localparam int MAX_WL = 64;

    typedef enum logic [2:0] {
        FS_OPCODE = 3'd0,
        FS_RS     = 3'd1,
        FS_RT     = 3'd2,
        FS_RD     = 3'd3,
        FS_SHAMT  = 3'd4,
        FS_FUNCT  = 3'd5,
        FS_IMM    = 3'd6,
        FS_PASS   = 3'd7
    } field_sel_e;

    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // Returns a MAX_WL-wide mask; callers size-cast it down to their word width.
    // The opcode field sits in the top opw bits of a wl-bit word.
    function automatic logic [MAX_WL-1:0] field_mask(input field_sel_e fs,
                                                     input int wl,
                                                     input int opw);
        logic [MAX_WL-1:0] m;
        int hi;
        int lo;
        m  = '0;
        hi = -1;
        lo = 0;
        case (fs)
            FS_OPCODE: begin hi = wl - 1;   lo = wl - opw; end
            FS_RS:     begin hi = RS_HI;    lo = RS_LO;    end
            FS_RT:     begin hi = RT_HI;    lo = RT_LO;    end
            FS_RD:     begin hi = RD_HI;    lo = RD_LO;    end
            FS_SHAMT:  begin hi = SHAMT_HI; lo = SHAMT_LO; end
            FS_FUNCT:  begin hi = FUNCT_HI; lo = FUNCT_LO; end
            FS_IMM:    begin hi = IMM_HI;   lo = IMM_LO;   end
            default:   begin hi = -1;       lo = 0;        end
        endcase
        for (int i = 0; i < MAX_WL; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/instr_field_merge_if.sv
// Handshake bundle for instr_field_merge.
//   master: drives in_valid/in1/in2/field_sel and out_ready (upstream + downstream side)
//   slave : the merger; drives in_ready, out_valid and out_word
interface instr_field_merge_if #(
    parameter int WL = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in1;
    logic [WL-1:0] in2;
    logic [2:0]    field_sel;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] out_word;

    modport master (
        output in_valid, in1, in2, field_sel, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in1, in2, field_sel, out_ready,
        output in_ready, out_valid, out_word
    );
endinterface

// File: rtl/instr_field_merge_fifo.sv
// merge_fifo: WL x DEPTH synchronous FIFO holding merged words.
// Ports: clk, rst_n (async active-low), push/pop requests (ignored when
// full/empty respectively), din, dout (entry at read pointer), full, empty.
// Storage is cleared on reset so dout reads zero straight out of reset.
module merge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // A full FIFO refuses the push even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_field_merge.sv
// instr_field_merge: buffered instruction-word field merger.
// Each accepted transaction replaces the field chosen by field_sel in base
// word in1 with the same field of donor word in2; results drain in order
// through a DEPTH-entry buffer.
// Ports: clk, rst_n (async active-low), bus (slave side of the handshake
// bundle), merge_cnt (accepted transactions, wraps modulo 2^CW).
module instr_field_merge
    import instr_fmt_pkg::*;
#(
    parameter int WL    = 32,
    parameter int OPW   = 6,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_field_merge_if.slave  bus,
    output logic [CW-1:0]       merge_cnt
);
    logic [WL-1:0] mask;
    logic [WL-1:0] merged;
    logic          full;
    logic          empty;
    logic          xfer;

    always_comb begin
        mask   = WL'(field_mask(field_sel_e'(bus.field_sel), WL, OPW));
        merged = (bus.in2 & mask) | (bus.in1 & ~mask);
    end

    // in_ready comes only from the registered fill level, never from out_ready.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign xfer          = bus.in_valid && !full;

    merge_fifo #(
        .W     (WL),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (bus.out_ready),
        .din   (merged),
        .dout  (bus.out_word),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) merge_cnt <= '0;
        else if (xfer) merge_cnt <= merge_cnt + 1'b1;
    end
endmodule

// File: tb/tb_instr_field_merge.sv
module tb_instr_field_merge;
    localparam int WL    = 32;
    localparam int OPW   = 6;
    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] merge_cnt;

    instr_field_merge_if #(.WL(WL)) bus ();

    instr_field_merge #(
        .WL    (WL),
        .OPW   (OPW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .merge_cnt (merge_cnt)
    );

    always #5 clk = ~clk;

    int            total  = 0;
    int            passed = 0;
    logic [WL-1:0] q[$];
    int            mcnt   = 0;

    // Reference merge straight from the field table.
    function automatic logic [WL-1:0] exp_merge(input logic [WL-1:0] a,
                                                input logic [WL-1:0] b,
                                                input logic [2:0]    fs);
        logic [WL-1:0] m;
        case (fs)
            3'd0:    m = ~({WL{1'b1}} >> OPW);
            3'd1:    m = 32'h1F << 21;
            3'd2:    m = 32'h1F << 16;
            3'd3:    m = 32'h1F << 11;
            3'd4:    m = 32'h1F << 6;
            3'd5:    m = 32'h3F;
            3'd6:    m = 32'hFFFF;
            default: m = '0;
        endcase
        return (b & m) | (a & ~m);
    endfunction

    task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge: drive, check against the model, clock once.
    task automatic step(input logic iv, input logic [WL-1:0] a, input logic [WL-1:0] b,
                        input logic [2:0] fs, input logic ordy);
        bit push_m;
        bit pop_m;
        bus.in_valid  = iv;
        bus.in1       = a;
        bus.in2       = b;
        bus.field_sel = fs;
        bus.out_ready = ordy;
        #1;
        chk("in_ready",  WL'(bus.in_ready),  WL'(q.size() != DEPTH));
        chk("out_valid", WL'(bus.out_valid), WL'(q.size() != 0));
        if (q.size() != 0) chk("out_word", bus.out_word, q[0]);
        chk("merge_cnt", WL'(merge_cnt), WL'(mcnt % (2 ** CW)));
        push_m = iv && (q.size() != DEPTH);
        pop_m  = ordy && (q.size() != 0);
        @(posedge clk);
        if (pop_m) void'(q.pop_front());
        if (push_m) begin
            q.push_back(exp_merge(a, b, fs));
            mcnt++;
        end
        @(negedge clk);
    endtask

    task automatic rstep(input logic iv, input logic ordy);
        step(iv, $urandom, $urandom, 3'($urandom_range(7)), ordy);
    endtask

    logic [WL-1:0] wa, wb, wc, wd;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.field_sel = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_in_ready",  WL'(bus.in_ready),  WL'(1));
        chk("rst_out_valid", WL'(bus.out_valid), WL'(0));
        chk("rst_merge_cnt", WL'(merge_cnt),     WL'(0));
        chk("rst_out_word",  bus.out_word,       '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Opcode merge
        step(1'b1, 32'h012A4020, 32'h8C000000, 3'd0, 1'b1);
        chk("opcode_word",  bus.out_word,       32'h8D2A4020);
        chk("opcode_valid", WL'(bus.out_valid), WL'(1));
        chk("opcode_cnt",   WL'(merge_cnt),     WL'(1));
        step(1'b0, '0, '0, 3'd0, 1'b1);
        step(1'b0, '0, '0, 3'd0, 1'b1);

        // Other field modes
        step(1'b1, 32'h2008FFFF, 32'h00001234, 3'd6, 1'b1);
        chk("imm_word", bus.out_word, 32'h20081234);
        step(1'b1, 32'h012A4020, 32'h00000022, 3'd5, 1'b1);
        chk("funct_word", bus.out_word, 32'h012A4022);
        step(1'b1, 32'h12345678, $urandom, 3'd7, 1'b1);
        chk("pass_word", bus.out_word, 32'h12345678);
        step(1'b1, 32'hFFFFFFFF, 32'h00000000, 3'd1, 1'b1);
        chk("rs_word", bus.out_word, 32'hFC1FFFFF);
        step(1'b0, '0, '0, 3'd0, 1'b1);

        // Backpressure: third word must be held off while full
        wa = $urandom; wb = $urandom; wc = $urandom;
        step(1'b1, wa, wb, 3'd2, 1'b0);
        step(1'b1, wb, wc, 3'd3, 1'b0);
        step(1'b1, wc, wa, 3'd4, 1'b0);
        chk("bp_in_ready_low", WL'(bus.in_ready), WL'(0));
        step(1'b1, wc, wa, 3'd4, 1'b0);
        step(1'b1, wc, wa, 3'd4, 1'b0);
        step(1'b1, wc, wa, 3'd4, 1'b1);
        step(1'b1, wc, wa, 3'd4, 1'b1);
        step(1'b0, '0, '0, 3'd0, 1'b1);
        step(1'b0, '0, '0, 3'd0, 1'b1);

        // Simultaneous push and pop at count 1
        rstep(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) rstep(1'b1, 1'b1);
        step(1'b0, '0, '0, 3'd0, 1'b1);
        step(1'b0, '0, '0, 3'd0, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) rstep(1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 3'd0, 1'b1);

        // Asynchronous reset while full
        rstep(1'b1, 1'b0);
        rstep(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", WL'(bus.out_valid), WL'(0));
        chk("midrst_in_ready",  WL'(bus.in_ready),  WL'(1));
        chk("midrst_merge_cnt", WL'(merge_cnt),     WL'(0));
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap at CW=4, first word after reset checked explicitly
        wd = $urandom;
        for (int i = 1; i <= 17; i++) begin
            if (i == 1) begin
                step(1'b1, wd, 32'hA5A5A5A5, 3'd6, 1'b1);
                chk("post_rst_word", bus.out_word, {wd[31:16], 16'hA5A5});
            end else begin
                rstep(1'b1, 1'b1);
            end
            if (i == 15) chk("wrap_15", WL'(merge_cnt), WL'(15));
            if (i == 16) chk("wrap_0",  WL'(merge_cnt), WL'(0));
            if (i == 17) chk("wrap_1",  WL'(merge_cnt), WL'(1));
        end
        step(1'b0, '0, '0, 3'd0, 1'b1);
        step(1'b0, '0, '0, 3'd0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
